// File: rtl/gin_cfg_pkg.sv
// gin_cfg_pkg: loader FSM state encoding, default chain geometry (TAG_WIDTH_DEF, NUM_MCC_DEF) and chain_len() helper
package gin_cfg_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, VERIFY, DONE} state_t;
  localparam int TAG_WIDTH_DEF = 4;
  localparam int NUM_MCC_DEF = 12;
  function automatic int chain_len(input int num_mcc, input int tag_width);
    return num_mcc * tag_width;
  endfunction
endpackage

// File: rtl/gin_scan_piso.sv
// gin_scan_piso: parallel-load, LSB-first serial-out shifter (clk, rst clears, load<-par, shift, recirc rotates sout back in, sout=q[0])
module gin_scan_piso #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         recirc,
  input  logic [W-1:0] par,
  output logic         sout
);
  logic [W-1:0] q;
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= par;
    else if (shift) q <= {recirc & q[0], q[W-1:1]};
  assign sout = q[0];
endmodule

// File: rtl/gin_id_scan_loader.sv
// gin_id_scan_loader: loads cfg_ids into the MCC ID scan chain on start (link_clk/reset; start, cfg_ids, so_chain in; se_chain, si_chain, busy, done, cfg_active, cfg_valid, verify_err out); GIN_SCAN_VERIFY_EN adds a readback VERIFY pass
module gin_id_scan_loader
  import gin_cfg_pkg::*;
#(
  parameter int TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int NUM_MCC = NUM_MCC_DEF
) (
  input  logic                         link_clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_MCC*TAG_WIDTH-1:0] cfg_ids,
  input  logic                         so_chain,
  output logic                         se_chain,
  output logic                         si_chain,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_active,
  output logic                         cfg_valid,
  output logic                         verify_err
);
  localparam int L = chain_len(NUM_MCC, TAG_WIDTH);
  localparam int CNT_WIDTH = $clog2(NUM_MCC*TAG_WIDTH) + 1;
  state_t state, nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [L-1:0] stream;
  logic accept, last, shifting, piso_clr, err_now;
  for (genvar k = 0; k < NUM_MCC; k++) begin : g_rev
    assign stream[(NUM_MCC-1-k)*TAG_WIDTH +: TAG_WIDTH] = cfg_ids[k*TAG_WIDTH +: TAG_WIDTH];
  end
`ifdef GIN_SCAN_VERIFY_EN
  localparam state_t AFTER_SHIFT = VERIFY;
  localparam logic RECIRC = 1'b1;
  logic mismatch;
  assign mismatch = state == VERIFY && so_chain != si_chain;
  assign err_now = verify_err || mismatch;
  always_ff @(posedge link_clk)
    if (reset || accept) verify_err <= 1'b0;
    else verify_err <= err_now;
`else
  localparam state_t AFTER_SHIFT = DONE;
  localparam logic RECIRC = 1'b0;
  logic unused_so;
  assign unused_so = so_chain;
  assign err_now = 1'b0;
  assign verify_err = 1'b0;
`endif
  always_comb begin
    accept = state == IDLE && start;
    shifting = state == SHIFT || state == VERIFY;
    last = cnt == CNT_WIDTH'(L - 1);
    nxt = state == IDLE ? (start ? SHIFT : IDLE) :
          state == SHIFT ? (last ? AFTER_SHIFT : SHIFT) :
          state == VERIFY ? (last ? DONE : VERIFY) : IDLE;
    piso_clr = reset || nxt == DONE;
  end
  always_ff @(posedge link_clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      se_chain <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      cfg_valid <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= shifting && !last ? cnt + 1'b1 : '0;
      se_chain <= nxt == SHIFT || nxt == VERIFY;
      busy <= nxt != IDLE;
      done <= nxt == DONE;
      cfg_valid <= accept ? 1'b0 : nxt == DONE ? !err_now : cfg_valid;
    end
  assign cfg_active = busy;
  gin_scan_piso #(.W(L)) u_piso (
    .clk(link_clk),
    .rst(piso_clr),
    .load(accept),
    .shift(shifting),
    .recirc(RECIRC),
    .par(stream),
    .sout(si_chain)
  );
endmodule

// File: doc/gin_id_scan_loader.md
Name: gin_id_scan_loader

Overview:
- Configures the tag-ID registers of a daisy-chained row of GIN multicast controllers (MCCs) through their serial ID scan chain (`se_id`/`si_id`/`so_id`).
- Captures a parallel table of IDs on `start`, serialises it into the chain and reports completion.
- Holds `cfg_active` high so the GIN bus master stalls traffic while the MCC IDs are in flux.
- Sits between the top-level configuration sequencer and each GIN row.

Parameters:
- `TAG_WIDTH`, 4, width of one MCC ID.
- `NUM_MCC`, 12, number of MCCs in the chain.
- `CNT_WIDTH`, `$clog2(NUM_MCC*TAG_WIDTH)+1`, width of the bit counter (derived; not overridden).

Ports:
- `link_clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request load; sampled only in IDLE.
- `cfg_ids`  in  `NUM_MCC*TAG_WIDTH`  ID of MCC k at `[k*TAG_WIDTH +: TAG_WIDTH]`; captured on accepted `start`.
- `so_chain`  in  1  `so_id` of MCC `NUM_MCC-1`.
- `se_chain`  out  1  drives `se_id` of every MCC.
- `si_chain`  out  1  drives `si_id` of MCC 0.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle completion pulse.
- `cfg_active`  out  1  equals `busy`; traffic-gating request.
- `cfg_valid`  out  1  chain holds a completely loaded ID table.
- `verify_err`  out  1  readback mismatch (present only with the macro; tied 0 otherwise).

Behaviour:
- Chain model:
  - Each MCC shifts right when `se=1`: `q <= {si, q[TAG_WIDTH-1:1]}`, `so = q[0]`.
  - MCC k `so` feeds MCC k+1 `si`.
  - Total chain length L = `NUM_MCC*TAG_WIDTH`.
- Stream order: MCC `NUM_MCC-1` ID first, LSB first, then MCC `NUM_MCC-2`, …, MCC 0 MSB last. The stream is built from `cfg_ids` into a shift register at accept.
- FSM states:
  - IDLE: `start=1` → capture stream, clear counter, clear `cfg_valid` and `verify_err` → SHIFT.
  - SHIFT: `se_chain=1`, `si_chain` = current stream bit. Counter increments each cycle. After L cycles → DONE, or → VERIFY when the macro is defined.
  - DONE: `done=1`, `se_chain=0`, `cfg_valid=1` → IDLE.
- All outputs are registered.
- Latency: `start` accepted at edge 0. `se_chain` is high for exactly L cycles (edges 1..L). `done` is high in cycle L+1.
- `se_chain` is never high outside SHIFT/VERIFY.
- `si_chain` is 0 whenever `se_chain=0`.
- `start` while not IDLE: ignored, no queuing. `start` held high continuously: a new load starts the cycle after each DONE.
- Counter stops at L-1 then resets; no wrap beyond the terminal count.
- Reset mid-operation:
  - Next edge: state IDLE, `se_chain=0`, `si_chain=0`, `busy=0`, `done=0`, `cfg_valid=0`, `verify_err=0`.
  - Chain contents are undefined; `cfg_valid=0` signals that a reload is required.
- Reset values: all outputs 0.
- `cfg_ids` changes after accept do not affect the load in progress.

Optional Feature:
- Macro `GIN_SCAN_VERIFY_EN`.
- Defined: after SHIFT, a VERIFY state runs L further cycles.
  - `se_chain=1` and the same stream is re-injected, so the chain contents are preserved.
  - Each cycle, `so_chain` is compared against stream bit i; any mismatch sets sticky `verify_err`.
  - DONE follows at cycle 2L+1. `cfg_valid` is set only if `verify_err=0`.
- Undefined: no VERIFY state, `verify_err` tied 0, `done` at L+1.

Decomposition:
- Package `gin_cfg_pkg`: state enum (IDLE, SHIFT, VERIFY, DONE), `localparam` default `TAG_WIDTH`/`NUM_MCC`, and function `chain_len(num_mcc, tag_width)`.
- Sub-module `gin_scan_piso`: parallel-load, LSB-first serial-out shift register with optional recirculate (recirculate used by VERIFY).

Test Plan:
- Reset, then `start` with `NUM_MCC=12` and IDs k→k (0..11): `se_chain` high exactly 48 cycles, `done` at cycle 49, `cfg_valid=1`. A behavioural chain model holds `q_id[k]=k` for all k.
- IDs all 4'hF, then a second load with all 4'h0: every model MCC reads 0; `cfg_valid` drops in the cycle after the second `start` and returns with the second `done`.
- `start` pulsed at cycles 5 and 20 during an active load: ignored. Exactly one `done`, 48 `se` cycles.
- `reset` asserted at shift cycle 20: next cycle all outputs 0, state IDLE. A subsequent full load completes correctly.
- With `GIN_SCAN_VERIFY_EN`, model MCC 7 bit 2 stuck-at-0, load ID 7 = 4'h4: `verify_err=1`, `cfg_valid=0`, `done` at cycle 97.
- With `GIN_SCAN_VERIFY_EN`, fault-free load: `verify_err=0`, `done` at 97, chain contents are the loaded IDs.
